// File: rtl/can_tx_mailbox.sv
// Multi-slot CAN transmit mailbox: nibble-loaded buffers, lowest-ID scheduler, req/ack/done engine handshake.
// Latency: commit to tx_req 2 cycles, done to next tx_req 2 cycles; a presented frame waits in REQ until tx_ack.
// Optional retry limit with tx_abort when CAN_TX_RETRY_LIMIT_EN is defined.
module can_tx_mailbox #(
    parameter int NIB_W      = 4,
    parameter int DATA_BYTES = 8,
    parameter int SLOTS      = 2,
    parameter int ID_W       = 11,
    parameter int RETRY_MAX  = 16,
    localparam int DATA_W    = DATA_BYTES * 8,
    localparam int NIBS      = DATA_W / NIB_W,
    localparam int SLOT_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1,
    localparam int IDX_W     = (NIBS > 1) ? $clog2(NIBS) : 1
) (
    input  logic              CLOCK_SIGNAL_IN,
    input  logic              RESET_N,
    input  logic              load_en,
    input  logic [SLOT_W-1:0] load_slot,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic [NIB_W-1:0]  load_nibble,
    input  logic              commit,
    input  logic [ID_W-1:0]   commit_id,
    input  logic [3:0]        commit_dlc,
    output logic              load_err,
    output logic [SLOTS-1:0]  slot_pending,
    output logic              tx_req,
    input  logic              tx_ack,
    input  logic              tx_done,
    input  logic              tx_err,
    output logic [ID_W-1:0]   tx_id,
    output logic [3:0]        tx_dlc,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_abort
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] DLC_MAX = (DATA_BYTES > 15) ? 4'd15 : 4'(DATA_BYTES);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q [SLOTS];
    logic [DATA_W-1:0] data_d [SLOTS];
    logic [ID_W-1:0]   id_q   [SLOTS];
    logic [ID_W-1:0]   id_d   [SLOTS];
    logic [3:0]        dlc_q  [SLOTS];
    logic [3:0]        dlc_d  [SLOTS];
    logic [SLOTS-1:0]  pend_q, pend_d;
    logic [SLOT_W-1:0] cur_q, cur_d;
    logic              tx_req_q, tx_req_d;
    logic [ID_W-1:0]   tx_id_q, tx_id_d;
    logic [3:0]        tx_dlc_q, tx_dlc_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              load_err_q, load_err_d;

    logic              any_pend;
    logic [SLOT_W-1:0] sel_idx;
    logic [ID_W-1:0]   sel_id;
    logic              slot_busy;
    logic              idx_ok;
    logic              wr_ok;
    logic              cm_ok;
    logic              err_evt;
    logic              done_evt;
    logic              limit_hit;
    logic              clr_cur;
    logic [3:0]        dlc_clamped;

    // Strict '<' while scanning upward keeps the lowest slot index on equal IDs.
    always_comb begin
        any_pend = 1'b0;
        sel_idx  = '0;
        sel_id   = '0;
        for (int s = 0; s < SLOTS; s++) begin
            if (pend_q[s] && (!any_pend || (id_q[s] < sel_id))) begin
                any_pend = 1'b1;
                sel_idx  = SLOT_W'(s);
                sel_id   = id_q[s];
            end
        end
    end

    // Out-of-range slot numbers (non power-of-two SLOTS) count as busy.
    always_comb begin
        slot_busy = 1'b1;
        for (int s = 0; s < SLOTS; s++) begin
            if (load_slot == SLOT_W'(s)) begin
                slot_busy = pend_q[s];
            end
        end
    end

    assign idx_ok      = (int'(load_idx) < NIBS);
    assign wr_ok       = load_en & ~slot_busy & idx_ok;
    assign cm_ok       = commit & ~slot_busy;
    assign dlc_clamped = (commit_dlc > DLC_MAX) ? DLC_MAX : commit_dlc;

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        tx_req_d  = tx_req_q;
        tx_id_d   = tx_id_q;
        tx_dlc_d  = tx_dlc_q;
        tx_data_d = tx_data_q;
        err_evt   = 1'b0;
        done_evt  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_pend) begin
                    cur_d     = sel_idx;
                    tx_id_d   = sel_id;
                    tx_dlc_d  = dlc_q[sel_idx];
                    tx_data_d = data_q[sel_idx];
                    tx_req_d  = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (tx_err) begin
                    tx_req_d = 1'b0;
                    err_evt  = 1'b1;
                    state_d  = IDLE;
                end else if (tx_ack) begin
                    tx_req_d = 1'b0;
                    state_d  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (tx_err) begin
                    err_evt = 1'b1;
                    state_d = IDLE;
                end else if (tx_done) begin
                    done_evt = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                tx_req_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    assign clr_cur = done_evt | limit_hit;

    // The slot being cleared is pending, so it never collides with a host write.
    always_comb begin
        data_d     = data_q;
        id_d       = id_q;
        dlc_d      = dlc_q;
        pend_d     = pend_q;
        load_err_d = (load_en & ~wr_ok) | (commit & ~cm_ok);
        if (wr_ok) begin
            data_d[load_slot][int'(load_idx) * NIB_W +: NIB_W] = load_nibble;
        end
        if (cm_ok) begin
            id_d[load_slot]   = commit_id;
            dlc_d[load_slot]  = dlc_clamped;
            pend_d[load_slot] = 1'b1;
        end
        if (clr_cur) begin
            data_d[cur_q] = '0;
            id_d[cur_q]   = '0;
            dlc_d[cur_q]  = '0;
            pend_d[cur_q] = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_SIGNAL_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            for (int s = 0; s < SLOTS; s++) begin
                data_q[s] <= '0;
                id_q[s]   <= '0;
                dlc_q[s]  <= '0;
            end
            pend_q     <= '0;
            cur_q      <= '0;
            tx_req_q   <= 1'b0;
            tx_id_q    <= '0;
            tx_dlc_q   <= '0;
            tx_data_q  <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            id_q       <= id_d;
            dlc_q      <= dlc_d;
            pend_q     <= pend_d;
            cur_q      <= cur_d;
            tx_req_q   <= tx_req_d;
            tx_id_q    <= tx_id_d;
            tx_dlc_q   <= tx_dlc_d;
            tx_data_q  <= tx_data_d;
            load_err_q <= load_err_d;
        end
    end

`ifdef CAN_TX_RETRY_LIMIT_EN
    localparam int CNT_W = $clog2(RETRY_MAX + 1);

    logic [CNT_W-1:0] retry_q [SLOTS];
    logic [CNT_W-1:0] retry_d [SLOTS];
    logic             abort_q, abort_d;

    always_comb begin
        retry_d   = retry_q;
        limit_hit = 1'b0;
        if (err_evt) begin
            if (retry_q[cur_q] == CNT_W'(RETRY_MAX - 1)) begin
                limit_hit      = 1'b1;
                retry_d[cur_q] = '0;
            end else begin
                retry_d[cur_q] = retry_q[cur_q] + 1'b1;
            end
        end else if (done_evt) begin
            retry_d[cur_q] = '0;
        end
        abort_d = limit_hit;
    end

    always_ff @(posedge CLOCK_SIGNAL_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int s = 0; s < SLOTS; s++) begin
                retry_q[s] <= '0;
            end
            abort_q <= 1'b0;
        end else begin
            retry_q <= retry_d;
            abort_q <= abort_d;
        end
    end

    assign tx_abort = abort_q;
`else
    assign limit_hit = 1'b0;
    assign tx_abort  = 1'b0;
`endif

    assign load_err     = load_err_q;
    assign slot_pending = pend_q;
    assign tx_req       = tx_req_q;
    assign tx_id        = tx_id_q;
    assign tx_dlc       = tx_dlc_q;
    assign tx_data      = tx_data_q;

endmodule

// File: tb/tb_can_tx_mailbox.sv
// Directed bench for can_tx_mailbox: vector table for load/commit/handshake, hand sequences for
// priority, pre-emption, retry, mid-frame reset, and out-of-range nibble index on a 6-byte instance.
module tb_can_tx_mailbox;

`ifdef CAN_TX_RETRY_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        load_en, commit, tx_ack, tx_done, tx_err;
    logic [0:0]  load_slot;
    logic [3:0]  load_idx, load_nibble, commit_dlc;
    logic [10:0] commit_id;
    logic        load_err, tx_req, tx_abort;
    logic [1:0]  slot_pending;
    logic [10:0] tx_id;
    logic [3:0]  tx_dlc;
    logic [63:0] tx_data;

    logic        b_load_en, b_commit;
    logic [0:0]  b_slot;
    logic [3:0]  b_idx, b_nib, b_cdlc;
    logic [10:0] b_cid;
    logic        b_load_err, b_req, b_abort;
    logic [1:0]  b_pend;
    logic [10:0] b_id;
    logic [3:0]  b_dlc;
    logic [47:0] b_data;

    can_tx_mailbox #(.RETRY_MAX(3)) dut (
        .CLOCK_SIGNAL_IN(clk), .RESET_N(rst_n),
        .load_en(load_en), .load_slot(load_slot), .load_idx(load_idx), .load_nibble(load_nibble),
        .commit(commit), .commit_id(commit_id), .commit_dlc(commit_dlc),
        .load_err(load_err), .slot_pending(slot_pending), .tx_req(tx_req),
        .tx_ack(tx_ack), .tx_done(tx_done), .tx_err(tx_err),
        .tx_id(tx_id), .tx_dlc(tx_dlc), .tx_data(tx_data), .tx_abort(tx_abort)
    );

    can_tx_mailbox #(.DATA_BYTES(6), .RETRY_MAX(3)) dut_b (
        .CLOCK_SIGNAL_IN(clk), .RESET_N(rst_n),
        .load_en(b_load_en), .load_slot(b_slot), .load_idx(b_idx), .load_nibble(b_nib),
        .commit(b_commit), .commit_id(b_cid), .commit_dlc(b_cdlc),
        .load_err(b_load_err), .slot_pending(b_pend), .tx_req(b_req),
        .tx_ack(1'b0), .tx_done(1'b0), .tx_err(1'b0),
        .tx_id(b_id), .tx_dlc(b_dlc), .tx_data(b_data), .tx_abort(b_abort)
    );

    typedef struct {
        logic        ld;
        logic [0:0]  slot;
        logic [3:0]  idx;
        logic [3:0]  nib;
        logic        cm;
        logic [10:0] cid;
        logic [3:0]  cdlc;
        logic        ack, done, err;
        logic        e_req;
        logic [1:0]  e_pend;
        logic        e_lerr;
        logic        chk_tx;
        logic [10:0] e_id;
        logic [3:0]  e_dlc;
        logic [63:0] e_data;
    } vec_t;

    vec_t tbl[$];
    int   n_total = 0;
    int   n_pass  = 0;
    bit   aborted = 1'b0;

    function automatic vec_t mk(input logic ld, input logic [0:0] slot, input logic [3:0] idx,
                                input logic [3:0] nib, input logic cm, input logic [10:0] cid,
                                input logic [3:0] cdlc, input logic ack, input logic done,
                                input logic err, input logic e_req, input logic [1:0] e_pend,
                                input logic e_lerr, input logic chk_tx, input logic [10:0] e_id,
                                input logic [3:0] e_dlc, input logic [63:0] e_data);
        vec_t v;
        v.ld = ld; v.slot = slot; v.idx = idx; v.nib = nib;
        v.cm = cm; v.cid = cid; v.cdlc = cdlc;
        v.ack = ack; v.done = done; v.err = err;
        v.e_req = e_req; v.e_pend = e_pend; v.e_lerr = e_lerr;
        v.chk_tx = chk_tx; v.e_id = e_id; v.e_dlc = e_dlc; v.e_data = e_data;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    task automatic clr_in();
        load_en = 1'b0; load_slot = '0; load_idx = '0; load_nibble = '0;
        commit = 1'b0; commit_id = '0; commit_dlc = '0;
        tx_ack = 1'b0; tx_done = 1'b0; tx_err = 1'b0;
        b_load_en = 1'b0; b_slot = '0; b_idx = '0; b_nib = '0;
        b_commit = 1'b0; b_cid = '0; b_cdlc = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr_in();
    endtask

    task automatic st(input string nm, input logic req, input logic [1:0] pend);
        chk({nm, ".req"}, 64'(tx_req), 64'(req));
        chk({nm, ".pend"}, 64'(slot_pending), 64'(pend));
    endtask

    task automatic txf(input string nm, input logic [10:0] id, input logic [3:0] dlc,
                       input logic [63:0] data);
        chk({nm, ".id"}, 64'(tx_id), 64'(id));
        chk({nm, ".dlc"}, 64'(tx_dlc), 64'(dlc));
        chk({nm, ".data"}, tx_data, data);
    endtask

    task automatic cmt(input logic [0:0] s, input logic [10:0] id, input logic [3:0] dlc);
        commit = 1'b1; load_slot = s; commit_id = id; commit_dlc = dlc;
        step();
    endtask

    task automatic ack_cyc();
        tx_ack = 1'b1;
        step();
    endtask

    initial begin
        clr_in();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        st("reset", 1'b0, 2'b00);
        txf("reset", 11'h0, 4'h0, 64'h0);
        chk("reset.lerr", 64'(load_err), 64'h0);
        chk("reset.abort", 64'(tx_abort), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(1, 0, 4'(i), 4'(i + 1), 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 11'h123, 4'd8, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 0, 1, 11'h123, 4'd8,
                         64'h0FEDCBA987654321));
        tbl.push_back(mk(1, 0, 0, 4'hA, 0, 0, 0, 0, 0, 0, 1, 2'b01, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 11'h055, 4'd2, 0, 0, 0, 1, 2'b01, 1, 1, 11'h123, 4'd8,
                         64'h0FEDCBA987654321));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 11'h7FF, 4'd15, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 0, 1, 11'h7FF, 4'd8, 64'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            load_en = tbl[k].ld; load_slot = tbl[k].slot; load_idx = tbl[k].idx;
            load_nibble = tbl[k].nib; commit = tbl[k].cm; commit_id = tbl[k].cid;
            commit_dlc = tbl[k].cdlc; tx_ack = tbl[k].ack; tx_done = tbl[k].done;
            tx_err = tbl[k].err;
            step();
            st($sformatf("row%0d", k), tbl[k].e_req, tbl[k].e_pend);
            chk($sformatf("row%0d.lerr", k), 64'(load_err), 64'(tbl[k].e_lerr));
            chk($sformatf("row%0d.abort", k), 64'(tx_abort), 64'h0);
            if (tbl[k].chk_tx)
                txf($sformatf("row%0d", k), tbl[k].e_id, tbl[k].e_dlc, tbl[k].e_data);
        end

        // Slot 0 is latched before slot 1 commits; losing arbitration re-selects the lower ID.
        cmt(0, 11'h200, 4'd2);   st("A.c0", 1'b0, 2'b01);
        cmt(1, 11'h100, 4'd3);   st("A.c1", 1'b1, 2'b11);
        chk("A.first_id", 64'(tx_id), 64'h200);
        tx_err = 1'b1; step();   st("A.lost", 1'b0, 2'b11);
        step();                  st("A.rearb", 1'b1, 2'b11);
        chk("A.sel_id", 64'(tx_id), 64'h100);
        chk("A.sel_dlc", 64'(tx_dlc), 64'h3);
        ack_cyc();               st("A.ack1", 1'b0, 2'b11);
        tx_done = 1'b1; step();  st("A.done1", 1'b0, 2'b01);
        step();                  st("A.next", 1'b1, 2'b01);
        chk("A.next_id", 64'(tx_id), 64'h200);
        ack_cyc();
        tx_done = 1'b1; step();  st("A.done0", 1'b0, 2'b00);

        // Errored frame stays pending; a lower ID committed meanwhile goes first.
        load_en = 1'b1; load_idx = 4'd0; load_nibble = 4'h5;
        cmt(0, 11'h300, 4'd1);   st("B.ldcm", 1'b0, 2'b01);
        step();                  st("B.req", 1'b1, 2'b01);
        txf("B.req", 11'h300, 4'd1, 64'h5);
        load_en = 1'b1; load_idx = 4'd0; load_nibble = 4'h9; load_slot = 1'b0;
        step();
        chk("B.rej_lerr", 64'(load_err), 64'h1);
        ack_cyc();               st("B.ack", 1'b0, 2'b01);
        chk("B.lerr_pulse", 64'(load_err), 64'h0);
        cmt(1, 11'h050, 4'd4);   st("B.c1", 1'b0, 2'b11);
        tx_err = 1'b1; step();   st("B.err", 1'b0, 2'b11);
        step();                  st("B.preempt", 1'b1, 2'b11);
        chk("B.preempt_id", 64'(tx_id), 64'h050);
        ack_cyc();
        tx_done = 1'b1; step();  st("B.done1", 1'b0, 2'b01);
        step();                  st("B.retry", 1'b1, 2'b01);
        txf("B.retry", 11'h300, 4'd1, 64'h5);
        ack_cyc();
        tx_done = 1'b1; tx_err = 1'b1; step();
        st("B.done_err", 1'b0, 2'b01);
        chk("B.done_err.abort", 64'(tx_abort), 64'h0);
        step();                  st("B.rereq", 1'b1, 2'b01);
        ack_cyc();
        tx_done = 1'b1; step();  st("B.done0", 1'b0, 2'b00);

        // Repeated errors: aborted on the third with the retry limit, otherwise re-requested.
        cmt(0, 11'h010, 4'd0);   st("C.commit", 1'b0, 2'b01);
        step();                  st("C.req", 1'b1, 2'b01);
        for (int r = 1; r <= 5 && !aborted; r++) begin
            ack_cyc();
            chk($sformatf("C.r%0d.ack_req", r), 64'(tx_req), 64'h0);
            tx_err = 1'b1; step();
            if (LIMIT && r == 3) begin
                chk("C.abort", 64'(tx_abort), 64'h1);
                chk("C.abort_pend", 64'(slot_pending), 64'h0);
                aborted = 1'b1;
                step();
                st("C.after_abort", 1'b0, 2'b00);
                chk("C.abort_pulse", 64'(tx_abort), 64'h0);
            end else begin
                chk($sformatf("C.r%0d.abort", r), 64'(tx_abort), 64'h0);
                chk($sformatf("C.r%0d.pend", r), 64'(slot_pending), 64'h1);
                step();
                st($sformatf("C.r%0d.rereq", r), 1'b1, 2'b01);
                chk($sformatf("C.r%0d.id", r), 64'(tx_id), 64'h010);
            end
        end
        if (!aborted) begin
            ack_cyc();
            tx_done = 1'b1; step(); st("C.done", 1'b0, 2'b00);
        end

        // Asynchronous reset in the middle of a frame.
        cmt(1, 11'h042, 4'd5);
        step();                  st("D.req", 1'b1, 2'b10);
        ack_cyc();               st("D.active", 1'b0, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        st("D.rst", 1'b0, 2'b00);
        txf("D.rst", 11'h0, 4'h0, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
            step();
            st($sformatf("D.post%0d", j), 1'b0, 2'b00);
        end

        // 6-byte instance: 12 nibbles, so index 12 and above is out of range.
        b_load_en = 1'b1; b_idx = 4'd11; b_nib = 4'h7; step();
        chk("E.idx11.lerr", 64'(b_load_err), 64'h0);
        b_load_en = 1'b1; b_idx = 4'd12; b_nib = 4'hF; step();
        chk("E.idx12.lerr", 64'(b_load_err), 64'h1);
        b_load_en = 1'b1; b_idx = 4'd15; b_nib = 4'hF; step();
        chk("E.idx15.lerr", 64'(b_load_err), 64'h1);
        b_commit = 1'b1; b_cid = 11'h001; b_cdlc = 4'd15; step();
        chk("E.pend", 64'(b_pend), 64'h1);
        chk("E.cm.lerr", 64'(b_load_err), 64'h0);
        step();
        chk("E.req", 64'(b_req), 64'h1);
        chk("E.dlc", 64'(b_dlc), 64'h6);
        chk("E.data", 64'(b_data), 64'h7000_0000_0000);
        chk("E.abort", 64'(b_abort), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
